// File: rtl/sdf_stage_sequencer_if.sv
// rtl/sdf_stage_sequencer_if.sv - sample stream and butterfly control bundle for one SDF FFT stage
interface sdf_stage_sequencer_if #(
    parameter int DW    = 14,
    parameter int TW_AW = 5
);
    logic              valid_i;
    logic [DW-1:0]     data_in_r;
    logic [DW-1:0]     data_in_i;
    logic              flush_i;
    logic [DW-1:0]     data_out_r;
    logic [DW-1:0]     data_out_i;
    logic [1:0]        mode;
    logic              sr_en;
    logic [TW_AW-1:0]  tw_idx;
    logic              valid_o;
    logic              drop_o;

    modport master (
        output valid_i, data_in_r, data_in_i, flush_i,
        input  data_out_r, data_out_i, mode, sr_en, tw_idx, valid_o, drop_o
    );

    modport slave (
        input  valid_i, data_in_r, data_in_i, flush_i,
        output data_out_r, data_out_i, mode, sr_en, tw_idx, valid_o, drop_o
    );
endinterface

// File: rtl/sdf_stage_sequencer.sv
// rtl/sdf_stage_sequencer.sv - radix-2 SDF stage sequencer: frame counter, butterfly mode, twiddle index, drain
module sdf_stage_sequencer #(
    parameter int DELAY   = 8,
    parameter int DW      = 14,
    parameter int TW_STEP = 1,
    parameter int TW_AW   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sdf_stage_sequencer_if.slave   bus
);
    localparam int CW = $clog2(2 * DELAY);
    localparam logic [CW-1:0]    LAST_FILL = CW'(DELAY - 1);
    localparam logic [CW-1:0]    LAST_BFLY = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0]    DLY       = CW'(DELAY);
    localparam logic [TW_AW-1:0] TW_STEP_W = TW_AW'(TW_STEP);

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_BFLY = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BFLY, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [DW-1:0]    data_out_r_q, data_out_r_d;
    logic [DW-1:0]    data_out_i_q, data_out_i_d;
    logic [1:0]       mode_q, mode_d;
    logic             sr_en_q, sr_en_d;
    logic [TW_AW-1:0] tw_idx_q, tw_idx_d;
    logic             valid_o_q, valid_o_d;
    logic             drop_o_q, drop_o_d;
    logic [TW_AW-1:0] bfly_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            data_out_r_q <= '0;
            data_out_i_q <= '0;
            mode_q       <= MODE_IDLE;
            sr_en_q      <= 1'b0;
            tw_idx_q     <= '0;
            valid_o_q    <= 1'b0;
            drop_o_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            data_out_r_q <= data_out_r_d;
            data_out_i_q <= data_out_i_d;
            mode_q       <= mode_d;
            sr_en_q      <= sr_en_d;
            tw_idx_q     <= tw_idx_d;
            valid_o_q    <= valid_o_d;
            drop_o_q     <= drop_o_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        data_out_r_d = data_out_r_q;
        data_out_i_d = data_out_i_q;
        mode_d       = mode_q;
        tw_idx_d     = tw_idx_q;
        sr_en_d      = 1'b0;
        valid_o_d    = 1'b0;
        drop_o_d     = 1'b0;
        // Offset into the second half-frame, truncated so the product wraps modulo 2**TW_AW
        bfly_pos     = TW_AW'(cnt_q - DLY);

        unique case (state_q)
            S_IDLE, S_FILL: begin
                if (bus.valid_i) begin
                    data_out_r_d = bus.data_in_r;
                    data_out_i_d = bus.data_in_i;
                    mode_d       = MODE_FILL;
                    sr_en_d      = 1'b1;
                    tw_idx_d     = '0;
                    valid_o_d    = pending_q;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST_FILL) begin
                        pending_d = 1'b0;
                        state_d   = S_BFLY;
                    end else begin
                        state_d   = S_FILL;
                    end
                end else if (bus.flush_i && state_q == S_FILL && cnt_q == '0 && pending_q) begin
                    // The flush edge itself emits the first drained difference
                    state_d      = S_DRAIN;
                    cnt_d        = CW'(1);
                    data_out_r_d = '0;
                    data_out_i_d = '0;
                    mode_d       = MODE_FILL;
                    sr_en_d      = 1'b1;
                    tw_idx_d     = '0;
                    valid_o_d    = 1'b1;
                end
            end
            S_BFLY: begin
                if (bus.valid_i) begin
                    data_out_r_d = bus.data_in_r;
                    data_out_i_d = bus.data_in_i;
                    mode_d       = MODE_BFLY;
                    sr_en_d      = 1'b1;
                    valid_o_d    = 1'b1;
                    tw_idx_d     = bfly_pos * TW_STEP_W;
                    if (cnt_q == LAST_BFLY) begin
                        pending_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_FILL;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drop_o_d = bus.valid_i;
                if (cnt_q == DLY) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    mode_d    = MODE_IDLE;
                end else begin
                    cnt_d        = cnt_q + 1'b1;
                    data_out_r_d = '0;
                    data_out_i_d = '0;
                    mode_d       = MODE_FILL;
                    sr_en_d      = 1'b1;
                    tw_idx_d     = '0;
                    valid_o_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.data_out_r = data_out_r_q;
    assign bus.data_out_i = data_out_i_q;
    assign bus.mode       = mode_q;
    assign bus.sr_en      = sr_en_q;
    assign bus.tw_idx     = tw_idx_q;
    assign bus.valid_o    = valid_o_q;
    assign bus.drop_o     = drop_o_q;
endmodule

// File: tb/tb_sdf_stage_sequencer.sv
// tb/tb_sdf_stage_sequencer.sv - scoreboard bench for sdf_stage_sequencer
module tb_sdf_stage_sequencer;
    localparam int DELAY   = 8;
    localparam int DW      = 14;
    localparam int TW_STEP = 1;
    localparam int TW_AW   = 5;

    logic clk;
    logic rst_n;

    sdf_stage_sequencer_if #(.DW(DW), .TW_AW(TW_AW)) bus ();

    sdf_stage_sequencer #(
        .DELAY(DELAY), .DW(DW), .TW_STEP(TW_STEP), .TW_AW(TW_AW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic             sr_en;
        logic             valid_o;
        logic             drop;
        logic [TW_AW-1:0] tw;
        logic [DW-1:0]    dr;
        logic [DW-1:0]    di;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vo_cnt  = 0;
    int   drop_cnt = 0;

    // Reference model state: 0 idle, 1 fill, 2 bfly, 3 drain
    int            m_state, m_cnt, m_drain;
    logic          m_pend;
    logic [1:0]    m_mode;
    logic [TW_AW-1:0] m_tw;
    logic [DW-1:0] m_dr, m_di;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i,
                              input logic f, output exp_t e);
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_drain = 0; m_pend = 0;
            m_mode = 0; m_tw = 0; m_dr = 0; m_di = 0;
        end
        e.sr_en = 0; e.valid_o = 0; e.drop = 0;
        if (rst_n) begin
            if (m_state == 0 || m_state == 1) begin
                if (v) begin
                    m_dr = r; m_di = i; m_mode = 2'b01; m_tw = 0;
                    e.sr_en = 1; e.valid_o = m_pend;
                    if (m_cnt == DELAY - 1) begin m_pend = 0; m_state = 2; end
                    else m_state = 1;
                    m_cnt++;
                end else if (f && m_state == 1 && m_cnt == 0 && m_pend) begin
                    m_state = 3; m_drain = DELAY - 1;
                    m_dr = 0; m_di = 0; m_mode = 2'b01; m_tw = 0;
                    e.sr_en = 1; e.valid_o = 1;
                end
            end else if (m_state == 2) begin
                if (v) begin
                    m_dr = r; m_di = i; m_mode = 2'b10;
                    m_tw = TW_AW'(((m_cnt - DELAY) * TW_STEP) % (1 << TW_AW));
                    e.sr_en = 1; e.valid_o = 1;
                    if (m_cnt == 2 * DELAY - 1) begin m_pend = 1; m_cnt = 0; m_state = 1; end
                    else m_cnt++;
                end
            end else begin
                e.drop = v;
                if (m_drain > 0) begin
                    m_drain--;
                    m_dr = 0; m_di = 0; m_mode = 2'b01; m_tw = 0;
                    e.sr_en = 1; e.valid_o = 1;
                end else begin
                    m_state = 0; m_pend = 0; m_mode = 2'b00;
                end
            end
        end
        e.mode = m_mode; e.tw = m_tw; e.dr = m_dr; e.di = m_di;
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("mode",    32'(bus.mode),       32'(e.mode));
            chk("sr_en",   32'(bus.sr_en),      32'(e.sr_en));
            chk("valid_o", 32'(bus.valid_o),    32'(e.valid_o));
            chk("drop_o",  32'(bus.drop_o),     32'(e.drop));
            chk("data_r",  32'(bus.data_out_r), 32'(e.dr));
            chk("data_i",  32'(bus.data_out_i), 32'(e.di));
            if (e.sr_en) chk("tw_idx", 32'(bus.tw_idx), 32'(e.tw));
        end
        if (bus.valid_o) vo_cnt++;
        if (bus.drop_o) drop_cnt++;
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i, input logic f);
        exp_t e;
        bus.valid_i = v; bus.data_in_r = r; bus.data_in_i = i; bus.flush_i = f;
        model_step(v, r, i, f, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic samples(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, DW'($urandom), DW'($urandom), 1'b0);
    endtask

    task automatic idles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, DW'($urandom), DW'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) cycle(1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom));
        rst_n = 1'b1;
        vo_cnt = 0;
        drop_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.valid_i = 0; bus.data_in_r = 0; bus.data_in_i = 0; bus.flush_i = 0;

        // Reset with random inputs, then one back-to-back frame
        do_reset();
        chk("rst_mode", 32'(bus.mode), 32'd0);
        samples(2 * DELAY);
        chk("t1_vo_cnt", 32'(vo_cnt), 32'd8);

        // Continuous second frame, flush at cnt=0, drain then idle
        vo_cnt = 0;
        samples(2 * DELAY);
        cycle(1'b0, '0, '0, 1'b1);
        idles(DELAY + 1);
        chk("t2_vo_cnt", 32'(vo_cnt), 32'd24);
        chk("t2_mode_idle", 32'(bus.mode), 32'd0);

        // Alternating valid through a frame
        do_reset();
        for (int k = 0; k < 4 * DELAY; k++) cycle(1'(k % 2 == 0), DW'($urandom), DW'($urandom), 1'b0);
        chk("t3_vo_cnt", 32'(vo_cnt), 32'd8);

        // Flush in BFLY at cnt=11 is ignored
        do_reset();
        samples(11);
        cycle(1'b0, '0, '0, 1'b1);
        samples(5);
        chk("t4_vo_cnt", 32'(vo_cnt), 32'd8);
        cycle(1'b0, '0, '0, 1'b1);
        idles(DELAY + 1);
        chk("t4_drain_cnt", 32'(vo_cnt), 32'd16);

        // valid_i during DRAIN is dropped, drain length unchanged
        do_reset();
        samples(2 * DELAY);
        cycle(1'b0, '0, '0, 1'b1);
        for (int k = 0; k < DELAY + 1; k++) cycle(1'(k == 2 || k == 5), DW'($urandom), DW'($urandom), 1'b0);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("t5_vo_cnt", 32'(vo_cnt), 32'd16);
        chk("t5_mode_idle", 32'(bus.mode), 32'd0);

        // Asynchronous reset during BFLY
        do_reset();
        samples(12);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("arst_mode", 32'(bus.mode), 32'd0);
        chk("arst_sr_en", 32'(bus.sr_en), 32'd0);
        chk("arst_tw_idx", 32'(bus.tw_idx), 32'd0);
        chk("arst_data_r", 32'(bus.data_out_r), 32'd0);
        do_reset();
        samples(2 * DELAY);
        chk("t6_vo_cnt", 32'(vo_cnt), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
